// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the NZCV status-flag producer: ALU class
// encodings, flag bit positions and the reset value of the flag vector.
package status_flag_unit_pkg;

   // ALU classes. Codes 5..7 are the LOGIC class; the low bits select
   // the bitwise operation. A plain move of op_b is expressed as ORR with
   // op_a = 0.
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_ADC = 3'd1,
      OP_SUB = 3'd2,
      OP_SBC = 3'd3,
      OP_RSB = 3'd4,
      OP_AND = 3'd5,
      OP_ORR = 3'd6,
      OP_EOR = 3'd7
   } op_class_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [3:0] FLAGS_RESET = 4'b0000;

   // True for the classes that go through the adder.
   function automatic logic is_arith(input op_class_e op);
      return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) ||
             (op == OP_SBC) || (op == OP_RSB);
   endfunction

endpackage

// File: rtl/status_flag_unit_flag_compute.sv
// Combinational E-stage ALU result and candidate NZCV flags.
// cin_i and v_i come from the forwarded flag vector so that ADC/SBC and
// the LOGIC class see the newest flags, committed or still pending.
module status_flag_unit_flag_compute
   import status_flag_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  op_class_e        op_class_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             shift_carry_i,
   input  logic             cin_i,
   input  logic             v_i,
   output logic [WIDTH-1:0] result_o,
   output logic [3:0]       flags_o
);

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             c;
   logic             arith;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH:0]   sum;

   // Map every arithmetic class onto x + y + c, where x is the minuend.
   always_comb begin
      x         = op_a_i;
      y         = op_b_i;
      c         = 1'b0;
      logic_res = '0;
      arith     = is_arith(op_class_i);
      case (op_class_i)
         OP_ADC:  c = cin_i;
         OP_SUB:  begin y = ~op_b_i; c = 1'b1;  end
         OP_SBC:  begin y = ~op_b_i; c = cin_i; end
         OP_RSB:  begin x = op_b_i;  y = ~op_a_i; c = 1'b1; end
         OP_AND:  logic_res = op_a_i & op_b_i;
         OP_ORR:  logic_res = op_a_i | op_b_i;
         OP_EOR:  logic_res = op_a_i ^ op_b_i;
         default: ;
      endcase
   end

   assign sum      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
   assign result_o = arith ? sum[WIDTH-1:0] : logic_res;

   // C is carry-out (not borrow) for subtracts because y is already inverted.
   always_comb begin
      flags_o         = FLAGS_RESET;
      flags_o[FLAG_N] = result_o[WIDTH-1];
      flags_o[FLAG_Z] = (result_o == '0);
      flags_o[FLAG_C] = arith ? sum[WIDTH] : shift_carry_i;
      flags_o[FLAG_V] = arith ? ((x[WIDTH-1] == y[WIDTH-1]) &&
                                 (result_o[WIDTH-1] != x[WIDTH-1]))
                              : v_i;
   end

endmodule

// File: rtl/status_flag_unit.sv
// NZCV producer: E-stage flag compute, a one-deep pending register and
// the architectural status register. flags_fwd_o is driven only from
// registers, so feeding its C bit back as ADC/SBC carry-in forms no loop.
module status_flag_unit
   import status_flag_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             exe_valid_i,
   input  logic             s_bit_i,
   input  logic             cond_pass_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  op_class_e        op_class_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             shift_carry_i,
   output logic [WIDTH-1:0] alu_result_o,
   output logic [3:0]       flags_fwd_o,
   output logic [3:0]       flags_arch_o,
   output logic             flag_pending_o
);

   logic [3:0] cand_flags;
   logic       qualify;

   logic [3:0] pend_q, pend_d;
   logic       pend_vld_q, pend_vld_d;
   logic [3:0] arch_q, arch_d;

   status_flag_unit_flag_compute #(.WIDTH(WIDTH)) u_flag_compute (
      .op_class_i    (op_class_i),
      .op_a_i        (op_a_i),
      .op_b_i        (op_b_i),
      .shift_carry_i (shift_carry_i),
      .cin_i         (flags_fwd_o[FLAG_C]),
      .v_i           (flags_fwd_o[FLAG_V]),
      .result_o      (alu_result_o),
      .flags_o       (cand_flags)
   );

   assign qualify = exe_valid_i & s_bit_i & cond_pass_i & ~stall_i & ~flush_i;

   // Commit the old pending value and load a new one on the same edge;
   // a stall freezes both registers.
   always_comb begin
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      arch_d     = arch_q;
      if (!stall_i) begin
         if (pend_vld_q) begin
            arch_d = pend_q;
         end
         if (qualify) begin
            pend_d     = cand_flags;
            pend_vld_d = 1'b1;
         end else begin
            pend_vld_d = 1'b0;
         end
      end
   end

   // Flag state registers; reset discards any pending update.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q     <= FLAGS_RESET;
         pend_vld_q <= 1'b0;
         arch_q     <= FLAGS_RESET;
      end else begin
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         arch_q     <= arch_d;
      end
   end

   assign flags_fwd_o    = pend_vld_q ? pend_q : arch_q;
   assign flags_arch_o   = arch_q;
   assign flag_pending_o = pend_vld_q;

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Producer side of the NZCV condition-flag interface: computes N/Z/C/V from execute-stage ALU operands and commits them to the architectural status register.
- Downstream condition evaluation and ADC/SBC carry-in read the same forwarded flag vector.
- Two-step pipeline: E-stage flag compute, then a one-deep pending register, then architectural commit.
- Handles stall, flush and the S-bit/condition-pass gating.

Parameters:
- WIDTH, 32, datapath width of operands and result.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- exe_valid  in  1  valid instruction in E stage
- s_bit  in  1  instruction requests a flag update
- cond_pass  in  1  instruction's condition evaluated true
- stall  in  1  freeze pending and architectural registers
- flush  in  1  kill the E-stage instruction this cycle
- op_class  in  3  ALU class (package encoding)
- op_a  in  WIDTH  first operand
- op_b  in  WIDTH  second operand (post-shifter)
- shift_carry  in  1  shifter carry-out, used by logical classes
- alu_result  out  WIDTH  combinational E-stage result
- flags_fwd  out  4  {N,Z,C,V}, newest committed-or-pending flags
- flags_arch  out  4  {N,Z,C,V}, architectural register
- flag_pending  out  1  pending update not yet committed

Behaviour:
- Reset (synchronous, rst high at clk edge): flags_arch=4'b0000, pending flags=4'b0000, flag_pending=0, so flags_fwd=0. Reset has priority over every other input.
- Op classes: ADD, ADC, SUB, SBC, RSB, LOGIC.
  - ADD / ADC / SUB / SBC / RSB: arithmetic, compute in WIDTH+1 bits.
  - LOGIC: result supplied via op_b passthrough, or AND/ORR/EOR sub-encoded in package.
- Carry-in for ADC/SBC is flags_fwd[1]. It is never taken from flags_arch.
- ADD/ADC: sum=a+b+cin. C=sum[WIDTH]. V=(a[msb]==b[msb]) && (res[msb]!=a[msb]).
- SUB: a+~b+1. SBC: a+~b+C. RSB: b+~a+1.
  - C=carry-out, i.e. NOT borrow. SUB 5-5 gives C=1; SUB 3-5 gives C=0.
  - V=(x[msb]!=y[msb]) && (res[msb]!=x[msb]), where x is the minuend.
- LOGIC: C=shift_carry, V=flags_fwd[0] (unchanged).
- All classes: N=res[msb], Z=(res==0).
- qualify = exe_valid & s_bit & cond_pass & !stall & !flush.
- Pending register, per cycle, when not stalled:
  - if qualify: load candidate flags, flag_pending=1.
  - else: flag_pending=0.
- Commit: if flag_pending & !stall, then flags_arch <= pending flags at the same edge.
- Simultaneous commit and qualify: the old pending value commits and the new value loads on the same edge. No bubble, no lost update.
- Stall: pending register, flag_pending and flags_arch all hold. alu_result stays combinational.
- Flush: suppresses only the E-stage instruction. An already-pending older update still commits.
- Latency:
  - candidate to flags_fwd: 1 edge.
  - candidate to flags_arch: 2 edges (absent stall).
- flags_fwd = flag_pending ? pending : flags_arch. Combinational from registers only, with no path from E-stage inputs, so there is no combinational loop through ADC carry-in.
- cond_pass=0 or s_bit=0: no state change beyond the normal drain of pending.
- Reset mid-stall or with pending set: pending is discarded, not committed.

Decomposition:
- Shared package:
  - op_class encodings.
  - flag bit indices N=3, Z=2, C=1, V=0.
  - constant FLAGS_RESET=4'b0000.
- Sub-module flag_compute: purely combinational adder plus NZCV generation. Instanced once.
- The top holds the pending/architectural registers and the control logic.

Test Plan:
- Reset with pending set (ADD in flight, rst=1) -> next cycle flags_arch=0000, flag_pending=0, flags_fwd=0000.
- SUB a=5, b=5, s=1, cond_pass=1 -> +1 edge: flags_fwd=0110 (Z,C), flag_pending=1; +2 edges: flags_arch=0110.
- ADD 0x7FFFFFFF+1, s=1 -> flags=1001 (N,V). ADD 0xFFFFFFFF+1 -> flags=0110 (Z,C).
- Back-to-back:
  - SUB 3-5 (flags 1000), then ADC 1+1 next cycle -> ADC uses forwarded C=0, result=2, flags 0000.
  - flags_arch shows 1000 for one cycle, then 0000.
- Stall held 3 cycles while pending=0110 -> flags_arch unchanged, flag_pending stays 1; commits on the first edge after stall drops.
- Flush on qualifying SUB 5-5 while an older pending ADD exists -> older ADD commits, no new pending; s_bit=0 or cond_pass=0 -> flags never change.
